// File: rtl/on_the_fly_incr_interface.sv
// on_the_fly_incr_interface: MSD-first signed-digit accumulator with held result streamed back as signed digits
module on_the_fly_incr_interface #(
  parameter int    RADIX_MODE     = 1,
  parameter string ENCODING_MODE  = "signed-digit",
  parameter int    PIPLINE_ENABLE = 1,
  parameter int    ACCURATE_MAX   = 8,
  parameter int    DATA_LEN_WIDTH = 5,
  parameter int    EXTEND_WIDTH   = 1,
  parameter int    DATA_WIDTH     = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_mbus_wen,
  input  logic [DATA_WIDTH-1:0]     i_mbus_wdata,
  input  logic                      i_mbus_wvalid,
  input  logic                      i_mbus_wlast,
  input  logic                      i_mbus_wend,
  output logic                      o_mbus_wready,
  input  logic                      i_mbus_rrq,
  input  logic [DATA_LEN_WIDTH-1:0] i_mbus_rlen,
  output logic                      o_mbus_rready,
  output logic [DATA_WIDTH-1:0]     o_mbus_rdata,
  output logic                      o_mbus_rvalid,
  output logic                      o_mbus_rlast
);
  localparam int W = 1 + EXTEND_WIDTH + ACCURATE_MAX;
  localparam int KW = $clog2(ACCURATE_MAX + 1);
  localparam int CW = $clog2(W + 1);
  localparam bit BS = ENCODING_MODE == "borrow-save";
  localparam bit PIPE = PIPLINE_ENABLE != 0;
  localparam logic [1:0] POS = BS ? 2'b01 : 2'b10;
  localparam logic [1:0] NEG = BS ? 2'b11 : 2'b01;
  logic [W-1:0] acc, hold, sreg, unit, sum;
  logic [KW-1:0] k, hold_len, len, n_sel;
  logic [CW-1:0] rem;
  logic hold_full, busy, first, lock, pos, neg, accept, fin, load, done;
  // digit decode, weighted add, handshakes and read length selection
  always_comb begin
    pos = BS ? i_mbus_wdata[1:0] == 2'b01 : i_mbus_wdata[1:0] == 2'b10;
    neg = BS ? i_mbus_wdata[1:0] == 2'b11 : i_mbus_wdata[1:0] == 2'b01;
    unit = (k < KW'(ACCURATE_MAX)) ? W'(1) << (ACCURATE_MAX - RADIX_MODE * (int'(k) + 1)) : '0;
    sum = acc + (pos ? unit : neg ? -unit : '0);
    len = (k == KW'(ACCURATE_MAX)) ? k : k + KW'(1);
    o_mbus_wready = !hold_full && (PIPE || !lock);
    o_mbus_rready = !PIPE && hold_full && !busy;
    accept = i_mbus_wen && i_mbus_wvalid && o_mbus_wready;
    fin = accept && i_mbus_wlast && i_mbus_wend;
    load = hold_full && !busy && (PIPE || i_mbus_rrq);
    done = busy && rem == CW'(1);
    n_sel = (PIPE || i_mbus_rlen == '0) ? hold_len :
            (i_mbus_rlen > DATA_LEN_WIDTH'(ACCURATE_MAX)) ? KW'(ACCURATE_MAX) : KW'(i_mbus_rlen);
    o_mbus_rvalid = busy;
    o_mbus_rlast = done;
    o_mbus_rdata = (busy && sreg[W-1]) ? DATA_WIDTH'(first ? NEG : POS) : '0;
  end
  // accumulate one digit per accepted beat; the final operand empties the accumulator
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      acc <= '0;
      k <= '0;
    end else if (accept) begin
      acc <= fin ? '0 : sum;
      k <= i_mbus_wlast ? '0 : len;
    end
  end
  // hold buffer for a finished sum; lock keeps writers out until a requested stream ends
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      hold <= '0;
      hold_len <= '0;
      hold_full <= 1'b0;
      lock <= 1'b0;
    end else begin
      if (fin) begin
        hold <= sum;
        hold_len <= len;
      end
      hold_full <= fin || (hold_full && !load);
      lock <= fin || (lock && !done);
    end
  end
  // output shifter emits the held sum MSB-first, sign digit first
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sreg <= '0;
      rem <= '0;
      busy <= 1'b0;
      first <= 1'b0;
    end else if (load) begin
      sreg <= hold;
      rem <= CW'(1 + EXTEND_WIDTH) + CW'(n_sel);
      busy <= 1'b1;
      first <= 1'b1;
    end else if (busy) begin
      sreg <= sreg << 1;
      rem <= rem - CW'(1);
      busy <= !done;
      first <= 1'b0;
    end
  end
endmodule

// File: tb/tb_on_the_fly_incr_interface.sv
// tb_on_the_fly_incr_interface: directed checks of accumulate and stream-back in three configurations
module tb_on_the_fly_incr_interface;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, wvalid, wlast, wend, rrq;
  logic [2:0] wen;
  logic [1:0] wd, wdb;
  logic [4:0] rlen;
  logic [2:0] wready, rready, rvalid, rlast;
  logic [1:0] rdata [3];
  int total = 0;
  int bad = 0;
  on_the_fly_incr_interface u0 (
    .i_clk(clk), .i_rstn(rstn), .i_mbus_wen(wen[0]), .i_mbus_wdata(wd), .i_mbus_wvalid(wvalid),
    .i_mbus_wlast(wlast), .i_mbus_wend(wend), .o_mbus_wready(wready[0]), .i_mbus_rrq(rrq),
    .i_mbus_rlen(rlen), .o_mbus_rready(rready[0]), .o_mbus_rdata(rdata[0]),
    .o_mbus_rvalid(rvalid[0]), .o_mbus_rlast(rlast[0]));
  on_the_fly_incr_interface #(.ENCODING_MODE("borrow-save")) u1 (
    .i_clk(clk), .i_rstn(rstn), .i_mbus_wen(wen[1]), .i_mbus_wdata(wdb), .i_mbus_wvalid(wvalid),
    .i_mbus_wlast(wlast), .i_mbus_wend(wend), .o_mbus_wready(wready[1]), .i_mbus_rrq(rrq),
    .i_mbus_rlen(rlen), .o_mbus_rready(rready[1]), .o_mbus_rdata(rdata[1]),
    .o_mbus_rvalid(rvalid[1]), .o_mbus_rlast(rlast[1]));
  on_the_fly_incr_interface #(.PIPLINE_ENABLE(0)) u2 (
    .i_clk(clk), .i_rstn(rstn), .i_mbus_wen(wen[2]), .i_mbus_wdata(wd), .i_mbus_wvalid(wvalid),
    .i_mbus_wlast(wlast), .i_mbus_wend(wend), .o_mbus_wready(wready[2]), .i_mbus_rrq(rrq),
    .i_mbus_rlen(rlen), .o_mbus_rready(rready[2]), .o_mbus_rdata(rdata[2]),
    .o_mbus_rvalid(rvalid[2]), .o_mbus_rlast(rlast[2]));
  function automatic logic [1:0] to_bs(input logic [1:0] c);
    return c == 2'b10 ? 2'b01 : c == 2'b01 ? 2'b11 : 2'b00;
  endfunction
  task automatic send_op(input int inst, input int n, input logic [15:0] codes, input bit fin);
    for (int i = 0; i < n; i++) begin
      bit ok;
      int tries;
      ok = 1'b0;
      tries = 0;
      wd = codes[15-2*i -: 2];
      wdb = to_bs(wd);
      wen = 3'(1 << inst);
      wvalid = 1'b1;
      wlast = i == n - 1;
      wend = fin && i == n - 1;
      while (!ok && tries < 60) begin
        @(negedge clk);
        ok = wready[inst];
        @(posedge clk);
        #1;
        tries++;
      end
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL send_accept inst=%0d digit=%0d got=stalled exp=accepted", inst, i);
      end
    end
    wen = '0;
    wvalid = 1'b0;
    wlast = 1'b0;
    wend = 1'b0;
  endtask
  task automatic collect(input int inst, output int cnt, output logic [31:0] pk, output int lat);
    cnt = 0;
    pk = '0;
    lat = 0;
    @(negedge clk);
    while (!rvalid[inst] && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    while (rvalid[inst] && cnt < 16) begin
      pk = {pk[29:0], rdata[inst]};
      cnt++;
      if (rlast[inst]) break;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    wen = '0;
    wvalid = 1'b0;
    wlast = 1'b0;
    wend = 1'b0;
    rrq = 1'b0;
    rlen = '0;
    wd = '0;
    wdb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({rvalid[i], rlast[i], rready[i], wready[i]} !== 4'b0001) begin
        bad++;
        $display("FAIL reset_flags inst=%0d got=%b exp=0001", i, {rvalid[i], rlast[i], rready[i], wready[i]});
      end
      total++;
      if (rdata[i] !== 2'b00) begin
        bad++;
        $display("FAIL reset_rdata inst=%0d got=%b exp=00", i, rdata[i]);
      end
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask
  task automatic test_signed_digit;
    int cnt, lat;
    logic [31:0] pk;
    send_op(0, 8, 16'h21A1, 1'b1);
    collect(0, cnt, pk, lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL sd_latency got=%0d exp=1", lat); end
    total++;
    if (cnt !== 10) begin bad++; $display("FAIL sd_count got=%0d exp=10", cnt); end
    total++;
    if (pk !== 32'h00A8A) begin bad++; $display("FAIL sd_digits got=%h exp=%h", pk, 32'h00A8A); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_borrow_save;
    int cnt, lat;
    logic [31:0] pk;
    send_op(1, 8, 16'h21A1, 1'b1);
    collect(1, cnt, pk, lat);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL bs_latency got=%0d exp=1", lat); end
    total++;
    if (cnt !== 10) begin bad++; $display("FAIL bs_count got=%0d exp=10", cnt); end
    total++;
    if (pk !== 32'h00545) begin bad++; $display("FAIL bs_digits got=%h exp=%h", pk, 32'h00545); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_accumulate;
    int cnt, lat;
    logic [31:0] pk;
    send_op(0, 8, 16'h8000, 1'b0);
    @(negedge clk);
    total++;
    if (rvalid[0] !== 1'b0) begin bad++; $display("FAIL acc_silent got=%b exp=0", rvalid[0]); end
    @(posedge clk);
    #1;
    send_op(0, 8, 16'h8000, 1'b1);
    collect(0, cnt, pk, lat);
    total++;
    if (cnt !== 10) begin bad++; $display("FAIL acc_count got=%0d exp=10", cnt); end
    total++;
    if (pk !== 32'h20000) begin bad++; $display("FAIL acc_digits got=%h exp=%h", pk, 32'h20000); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_read_request;
    int cnt, lat;
    logic [31:0] pk;
    send_op(2, 8, 16'h21A1, 1'b1);
    rrq = 1'b1;
    rlen = 5'd4;
    @(negedge clk);
    total++;
    if (rready[2] !== 1'b1) begin bad++; $display("FAIL rq_rready got=%b exp=1", rready[2]); end
    total++;
    if (wready[2] !== 1'b0) begin bad++; $display("FAIL rq_wready_held got=%b exp=0", wready[2]); end
    @(posedge clk);
    #1;
    rrq = 1'b0;
    rlen = '0;
    collect(2, cnt, pk, lat);
    total++;
    if (lat !== 0) begin bad++; $display("FAIL rq_latency got=%0d exp=0", lat); end
    total++;
    if (cnt !== 6) begin bad++; $display("FAIL rq_count got=%0d exp=6", cnt); end
    total++;
    if (pk !== 32'h00A) begin bad++; $display("FAIL rq_digits got=%h exp=%h", pk, 32'h00A); end
    total++;
    if (wready[2] !== 1'b0) begin bad++; $display("FAIL rq_wready_last got=%b exp=0", wready[2]); end
    total++;
    if (rready[2] !== 1'b0) begin bad++; $display("FAIL rq_rready_drop got=%b exp=0", rready[2]); end
    @(negedge clk);
    total++;
    if (wready[2] !== 1'b1) begin bad++; $display("FAIL rq_wready_after got=%b exp=1", wready[2]); end
    @(posedge clk);
    #1;
    send_op(2, 3, 16'h9800, 1'b1);
    rrq = 1'b1;
    rlen = 5'd0;
    @(posedge clk);
    #1;
    rrq = 1'b0;
    collect(2, cnt, pk, lat);
    total++;
    if (cnt !== 5) begin bad++; $display("FAIL rq_len0_count got=%0d exp=5", cnt); end
    total++;
    if (pk !== 32'h00A) begin bad++; $display("FAIL rq_len0_digits got=%h exp=%h", pk, 32'h00A); end
    @(posedge clk);
    #1;
    send_op(2, 3, 16'h9800, 1'b1);
    rrq = 1'b1;
    rlen = 5'd31;
    @(posedge clk);
    #1;
    rrq = 1'b0;
    rlen = '0;
    collect(2, cnt, pk, lat);
    total++;
    if (cnt !== 10) begin bad++; $display("FAIL rq_sat_count got=%0d exp=10", cnt); end
    total++;
    if (pk !== 32'h02800) begin bad++; $display("FAIL rq_sat_digits got=%h exp=%h", pk, 32'h02800); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_back_to_back;
    logic [31:0] q[$];
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          logic [15:0] codes;
          logic [9:0] e;
          logic [31:0] x;
          int v;
          v = 0;
          codes = '0;
          for (int i = 0; i < 8; i++) begin
            int r;
            r = int'($urandom_range(0, 2));
            codes = {codes[13:0], r == 1 ? 2'b10 : r == 2 ? 2'b01 : 2'b00};
            v += (r == 1 ? 1 : r == 2 ? -1 : 0) * (1 << (7 - i));
          end
          e = 10'(v);
          x = '0;
          for (int b = 9; b >= 0; b--)
            x = {x[29:0], e[b] ? (b == 9 ? 2'b01 : 2'b10) : 2'b00};
          q.push_back(x);
          send_op(0, 8, codes, 1'b1);
          @(posedge clk);
          #1;
        end
      end
      begin
        for (int n = 0; n < 6; n++) begin
          int cnt, lat;
          logic [31:0] pk, ex;
          collect(0, cnt, pk, lat);
          ex = q.size() > 0 ? q.pop_front() : 32'hFFFFFFFF;
          total++;
          if (cnt !== 10) begin bad++; $display("FAIL b2b_count op=%0d got=%0d exp=10", n, cnt); end
          total++;
          if (pk !== ex) begin bad++; $display("FAIL b2b_digits op=%0d got=%h exp=%h", n, pk, ex); end
        end
      end
    join
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset_mid_stream;
    int cnt, lat;
    logic [31:0] pk;
    send_op(0, 8, 16'h21A1, 1'b1);
    send_op(0, 8, 16'h8000, 1'b0);
    @(negedge clk);
    total++;
    if (rvalid[0] !== 1'b1) begin bad++; $display("FAIL mid_streaming got=%b exp=1", rvalid[0]); end
    rstn = 1'b0;
    @(negedge clk);
    total++;
    if ({rvalid[0], rlast[0], wready[0]} !== 3'b001) begin
      bad++;
      $display("FAIL mid_abort got=%b exp=001", {rvalid[0], rlast[0], wready[0]});
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    send_op(0, 8, 16'h2000, 1'b1);
    collect(0, cnt, pk, lat);
    total++;
    if (cnt !== 10) begin bad++; $display("FAIL mid_count got=%0d exp=10", cnt); end
    total++;
    if (pk !== 32'h02000) begin bad++; $display("FAIL mid_acc_cleared got=%h exp=%h", pk, 32'h02000); end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_signed_digit();
    test_borrow_save();
    test_accumulate();
    test_read_request();
    test_back_to_back();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
